riscv_pipeline: RTL and testbench



---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/riscv_core.sv | 198 +++++++++++++++++++
 rtl/riscv_pipeline.sv | 46 ++++
 tb/tb_riscv_pipeline.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_pipeline core: opcodes, control encodings,
// the per-instruction control bundle and the decode helpers.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctrl_t;
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;

    // All-zero bundle is the NOP/bubble state.
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        result_src_t result_src;
        alu_ctrl_t   alu_ctrl;
    } ctrl_t;

    function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_src_t src);
        case (src)
            IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_ext = {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

    function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  alu_decode = sub ? ALU_SUB : ALU_ADD;
            3'b010:  alu_decode = ALU_SLT;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/riscv_core.sv
// Five-stage RV32I-subset pipeline: datapath, decode, hazard unit, register file
// and the cycle / retired-instruction performance counters.
module riscv_core
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_f,
    input  logic [31:0] instr_f,
    output logic        mem_write_m,
    output logic [31:0] alu_result_m,
    output logic [31:0] write_data_m,
    input  logic [31:0] read_data_m
);

    logic [31:0] instr_d, pc_d, pc4_d, rd1_d, rd2_d;
    logic [4:0]  rs1_d, rs2_d;
    ctrl_t       ctrl_d, ctrl_e;
    imm_src_t    imm_src_d;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [31:0] src_a_e, fwd_b_e, src_b_e, alu_result_e, target_e;
    logic        pc_src_e, lw_stall;
    logic        reg_write_m, reg_write_w;
    result_src_t result_src_m, result_src_w;
    logic [4:0]  rd_m, rd_w;
    logic [31:0] pc4_m, alu_result_w, read_data_w, pc4_w, result_w;
    logic [31:0] rf [32];
    logic [31:0] cycle_count, instr_retired;
    logic        unused_counters;

    assign rs1_d = instr_d[19:15];
    assign rs2_d = instr_d[24:20];
    assign rd1_d = (rs1_d == 5'd0) ? 32'd0 : rf[rs1_d];
    assign rd2_d = (rs2_d == 5'd0) ? 32'd0 : rf[rs2_d];

    always_comb begin
        ctrl_d    = '0;
        imm_src_d = IMM_I;
        case (instr_d[6:0])
            OP_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(instr_d[14:12], instr_d[30]);
            end
            OP_I: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(instr_d[14:12], 1'b0);
            end
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = RES_MEM;
            end
            OP_SW: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_src_d        = IMM_S;
            end
            OP_BEQ: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = ALU_SUB;
                imm_src_d       = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.result_src = RES_PC4;
                imm_src_d         = IMM_J;
            end
            default: ;
        endcase
    end

    assign lw_stall = (ctrl_e.result_src == RES_MEM) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A taken branch/jump in E overrides a load-use stall.
    always_ff @(posedge clk) begin
        if (reset)          pc_f <= '0;
        else if (pc_src_e)  pc_f <= target_e;
        else if (!lw_stall) pc_f <= pc_f + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset || pc_src_e) begin
            instr_d <= '0;
            pc_d    <= '0;
            pc4_d   <= '0;
        end else if (!lw_stall) begin
            instr_d <= instr_f;
            pc_d    <= pc_f;
            pc4_d   <= pc_f + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || pc_src_e || lw_stall) begin
            ctrl_e <= '0;
            {rd1_e, rd2_e, imm_e, pc_e, pc4_e} <= '0;
            {rs1_e, rs2_e, rd_e} <= '0;
        end else begin
            ctrl_e <= ctrl_d;
            rd1_e  <= rd1_d;
            rd2_e  <= rd2_d;
            imm_e  <= imm_ext(instr_d, imm_src_d);
            pc_e   <= pc_d;
            pc4_e  <= pc4_d;
            rs1_e  <= rs1_d;
            rs2_e  <= rs2_d;
            rd_e   <= instr_d[11:7];
        end
    end

    always_comb begin
        src_a_e = rd1_e;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e)      src_a_e = alu_result_m;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) src_a_e = result_w;
        fwd_b_e = rd2_e;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e)      fwd_b_e = alu_result_m;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) fwd_b_e = result_w;
    end

    assign src_b_e = ctrl_e.alu_src ? imm_e : fwd_b_e;

    always_comb begin
        case (ctrl_e.alu_ctrl)
            ALU_SUB: alu_result_e = src_a_e - src_b_e;
            ALU_AND: alu_result_e = src_a_e & src_b_e;
            ALU_OR:  alu_result_e = src_a_e | src_b_e;
            ALU_SLT: alu_result_e = {31'd0, $signed(src_a_e) < $signed(src_b_e)};
            default: alu_result_e = src_a_e + src_b_e;
        endcase
    end

    assign target_e = pc_e + imm_e;
    assign pc_src_e = (ctrl_e.branch && alu_result_e == 32'd0) || ctrl_e.jump;

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            {alu_result_m, write_data_m, pc4_m} <= '0;
            rd_m         <= '0;
        end else begin
            reg_write_m  <= ctrl_e.reg_write;
            mem_write_m  <= ctrl_e.mem_write;
            result_src_m <= ctrl_e.result_src;
            alu_result_m <= alu_result_e;
            write_data_m <= fwd_b_e;
            pc4_m        <= pc4_e;
            rd_m         <= rd_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_w  <= 1'b0;
            result_src_w <= RES_ALU;
            {alu_result_w, read_data_w, pc4_w} <= '0;
            rd_w         <= '0;
        end else begin
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= read_data_m;
            pc4_w        <= pc4_m;
            rd_w         <= rd_m;
        end
    end

    always_comb begin
        case (result_src_w)
            RES_MEM: result_w = read_data_w;
            RES_PC4: result_w = pc4_w;
            default: result_w = alu_result_w;
        endcase
    end

    // Falling-edge write lets Decode read a value retiring in the same cycle.
    always_ff @(negedge clk) begin
        if (reg_write_w && rd_w != 5'd0) rf[rd_w] <= result_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else begin
            cycle_count   <= cycle_count + 32'd1;
            instr_retired <= instr_retired + {31'd0, reg_write_w};
        end
    end

    // Counters are observed hierarchically, never read by the logic.
    assign unused_counters = ^{cycle_count, instr_retired};

endmodule

// File: rtl/riscv_pipeline.sv
// riscv_pipeline: pipelined core plus instruction and data memories; the
// Memory-stage data bus is exported so stores can be observed.
module riscv_pipeline
    import riscv_pkg::*;
#(
    parameter int    IMEM_WORDS = 64,
    parameter int    DMEM_WORDS = 64,
    parameter string IMEM_FILE  = "riscvtest.txt"
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] WriteDataM,
    output logic [31:0] DataAdrM,
    output logic        MemWriteM
);

    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] pc_f, instr_f, read_data_m;
    logic        unused_addr_bits;

    // Upper address bits are dropped, so both memories alias beyond their depth.
    assign instr_f     = imem[pc_f[IA+1:2]];
    assign read_data_m = dmem[DataAdrM[DA+1:2]];

    always_ff @(posedge clk) begin
        if (MemWriteM) dmem[DataAdrM[DA+1:2]] <= WriteDataM;
    end

    assign unused_addr_bits = ^{pc_f[31:IA+2], pc_f[1:0], DataAdrM[31:DA+2], DataAdrM[1:0]};

    riscv_core rv (
        .clk          (clk),
        .reset        (reset),
        .pc_f         (pc_f),
        .instr_f      (instr_f),
        .mem_write_m  (MemWriteM),
        .alu_result_m (DataAdrM),
        .write_data_m (WriteDataM),
        .read_data_m  (read_data_m)
    );

endmodule

// File: tb/tb_riscv_pipeline.sv
// Directed bench for riscv_pipeline: small programs are poked into instruction
// memory and every store seen in the Memory stage is scored against a queue.
module tb_riscv_pipeline;

    logic        clk;
    logic        reset;
    logic [31:0] WriteDataM, DataAdrM;
    logic        MemWriteM;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] cyc;
    } store_t;
    store_t exp_q[$];

    localparam logic [31:0] ANY_CYC = 32'hFFFF_FFFF;

    localparam logic [31:0] RISCVTEST [21] = '{
        32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
        32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463, 32'h00000293,
        32'h0023A233, 32'h005203B3, 32'h402383B3, 32'h0471AA23, 32'h06002103,
        32'h005104B3, 32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
        32'h00210063
    };

    riscv_pipeline #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("")) dut (
        .clk        (clk),
        .reset      (reset),
        .WriteDataM (WriteDataM),
        .DataAdrM   (DataAdrM),
        .MemWriteM  (MemWriteM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
             | ((imm & 32'h1F) << 7) | 32'h23;
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
             | (rs1 << 15) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put(input int byte_adr, input logic [31:0] w);
        dut.imem[byte_adr / 4] = w;
    endtask

    // Hold reset across a rising edge, then blank the instruction memory.
    task automatic enter_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
    endtask

    task automatic expect_store(input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] cyc);
        exp_q.push_back('{adr: adr, dat: dat, cyc: cyc});
    endtask

    // Runs a fixed window, scoring each store; leftover or extra stores show up in the count.
    task automatic run_window(input string tag, input int ncyc);
        int     want;
        int     seen;
        store_t e;
        want = exp_q.size();
        seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (MemWriteM === 1'b1) begin
                seen++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check({tag, " adr"}, DataAdrM, e.adr);
                    check({tag, " data"}, WriteDataM, e.dat);
                    if (e.cyc != ANY_CYC) check({tag, " cycle"}, dut.rv.cycle_count, e.cyc);
                end
            end
        end
        check({tag, " store count"}, seen, want);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset MemWriteM", {31'd0, MemWriteM}, 32'd0);
        check("reset DataAdrM", DataAdrM, 32'd0);
        check("reset WriteDataM", WriteDataM, 32'd0);
        check("reset pc", dut.rv.pc_f, 32'd0);
        check("reset cycle_count", dut.rv.cycle_count, 32'd0);
        check("reset instr_retired", dut.rv.instr_retired, 32'd0);

        // Back-to-back dependencies: sw fetched in cycle 3, reaches M in cycle 6 with no stalls.
        put(0,  enc_i(5, 0, 0, 1, 32'h13));
        put(4,  enc_r(0, 1, 1, 0, 2));
        put(8,  enc_r(0, 1, 2, 0, 3));
        put(12, enc_s(100, 3, 0));
        expect_store(32'd100, 32'd15, 32'd6);
        reset = 1'b0;
        @(negedge clk);
        check("first cycle cycle_count", dut.rv.cycle_count, 32'd1);
        check("first cycle pc", dut.rv.pc_f, 32'd4);
        run_window("fwd", 20);
        check("fwd instr_retired", dut.rv.instr_retired, 32'd3);
        check("fwd x3", dut.rv.rf[3], 32'd15);

        // Load-use: final sw is instruction 4, lands in M at cycle 7 plus one bubble.
        enter_reset();
        put(0,  enc_i(7, 0, 0, 6, 32'h13));
        put(4,  enc_s(8, 6, 0));
        put(8,  enc_i(8, 0, 2, 4, 32'h03));
        put(12, enc_i(1, 4, 0, 5, 32'h13));
        put(16, enc_s(100, 5, 0));
        expect_store(32'd8, 32'd7, ANY_CYC);
        expect_store(32'd100, 32'd8, 32'd8);
        reset = 1'b0;
        run_window("loaduse", 25);

        // Taken beq skips an addi that would overwrite x1.
        enter_reset();
        put(0,  enc_i(3, 0, 0, 1, 32'h13));
        put(4,  enc_i(3, 0, 0, 2, 32'h13));
        put(8,  enc_b(8, 2, 1));
        put(12, enc_i(99, 0, 0, 1, 32'h13));
        put(16, enc_s(100, 1, 0));
        expect_store(32'd100, 32'd3, ANY_CYC);
        reset = 1'b0;
        run_window("beq", 25);
        check("beq x1", dut.rv.rf[1], 32'd3);

        // jal from pc 4 to pc 16: x1 = 8, both skipped addis leave no trace.
        enter_reset();
        put(0,  enc_i(1, 0, 0, 5, 32'h13));
        put(4,  enc_j(12, 1));
        put(8,  enc_i(50, 0, 0, 5, 32'h13));
        put(12, enc_i(77, 0, 0, 1, 32'h13));
        put(16, enc_s(100, 1, 0));
        put(20, enc_s(104, 5, 0));
        expect_store(32'd100, 32'd8, ANY_CYC);
        expect_store(32'd104, 32'd1, ANY_CYC);
        reset = 1'b0;
        run_window("jal", 25);
        check("jal x1", dut.rv.rf[1], 32'd8);

        // Reference self-check program.
        enter_reset();
        for (int i = 0; i < 21; i++) dut.imem[i] = RISCVTEST[i];
        expect_store(32'd96, 32'd7, ANY_CYC);
        expect_store(32'd100, 32'd25, ANY_CYC);
        reset = 1'b0;
        run_window("riscvtest", 60);
        check("riscvtest dmem[100]", dut.dmem[25], 32'd25);

        // Mid-run reset: 8 cycles in no store has happened yet; memory must survive.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_window("prefix", 8);
        reset = 1'b1;
        @(negedge clk);
        check("midreset pc", dut.rv.pc_f, 32'd0);
        check("midreset MemWriteM", {31'd0, MemWriteM}, 32'd0);
        check("midreset DataAdrM", DataAdrM, 32'd0);
        check("midreset cycle_count", dut.rv.cycle_count, 32'd0);
        check("midreset dmem kept", dut.dmem[25], 32'd25);
        expect_store(32'd96, 32'd7, ANY_CYC);
        expect_store(32'd100, 32'd25, ANY_CYC);
        reset = 1'b0;
        run_window("rerun", 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
